// File: rtl/capture_sequencer.sv
// Frame sequencer for lidar acquisition. It arms the trigger decoder, gates
// sample_num samples for each trigger, and repeats this pulse_num times per frame.
module capture_sequencer #(
    parameter int SAMPLE_CNT_W = 16,
    parameter int PULSE_CNT_W  = 16,
    parameter int HOLDOFF      = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    capture_en_i,
    input  logic [SAMPLE_CNT_W-1:0] sample_num_i,
    input  logic [PULSE_CNT_W-1:0]  pulse_num_i,
    input  logic                    trigger_start_i,
    input  logic                    frame_ack_i,
    output logic                    trigger_ready_o,
    output logic                    sample_valid_o,
    output logic                    first_pulse_o,
    output logic                    frame_done_o,
    output logic                    busy_o,
    output logic [PULSE_CNT_W-1:0]  pulse_cnt_o
);

    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);

    typedef enum logic [2:0] {IDLE, ARM, CAPTURE, HOLD, WAIT_ACK} state_e;

    state_e                  state_q, state_d;
    logic [SAMPLE_CNT_W-1:0] sample_num_q, sample_num_d;
    logic [PULSE_CNT_W-1:0]  pulse_num_q, pulse_num_d;
    logic [SAMPLE_CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [PULSE_CNT_W-1:0]  pulse_cnt_q, pulse_cnt_d;
    logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;

    logic trigger_ready_q, trigger_ready_d;
    logic sample_valid_q, sample_valid_d;
    logic first_pulse_q, first_pulse_d;
    logic frame_done_q, frame_done_d;
    logic busy_q, busy_d;

    logic cfg_ok;
    logic last_sample;

    assign cfg_ok      = (sample_num_i != '0) && (pulse_num_i != '0);
    assign last_sample = (sample_cnt_q == sample_num_q - 1'b1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            sample_num_q    <= '0;
            pulse_num_q     <= '0;
            sample_cnt_q    <= '0;
            pulse_cnt_q     <= '0;
            hold_cnt_q      <= '0;
            trigger_ready_q <= 1'b0;
            sample_valid_q  <= 1'b0;
            first_pulse_q   <= 1'b0;
            frame_done_q    <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            sample_num_q    <= sample_num_d;
            pulse_num_q     <= pulse_num_d;
            sample_cnt_q    <= sample_cnt_d;
            pulse_cnt_q     <= pulse_cnt_d;
            hold_cnt_q      <= hold_cnt_d;
            trigger_ready_q <= trigger_ready_d;
            sample_valid_q  <= sample_valid_d;
            first_pulse_q   <= first_pulse_d;
            frame_done_q    <= frame_done_d;
            busy_q          <= busy_d;
        end
    end

    // Completing the frame on the last gate outranks an abort by the host.
    always_comb begin
        state_d      = state_q;
        sample_num_d = sample_num_q;
        pulse_num_d  = pulse_num_q;
        sample_cnt_d = sample_cnt_q;
        pulse_cnt_d  = pulse_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (capture_en_i && cfg_ok) begin
                    sample_num_d = sample_num_i;
                    pulse_num_d  = pulse_num_i;
                    pulse_cnt_d  = '0;
                    state_d      = ARM;
                end
            end
            ARM: begin
                if (trigger_start_i) begin
                    sample_cnt_d = '0;
                    state_d      = CAPTURE;
                end else if (!capture_en_i) begin
                    state_d = IDLE;
                end
            end
            CAPTURE: begin
                if (last_sample) begin
                    pulse_cnt_d = pulse_cnt_q + 1'b1;
                    if (pulse_cnt_q + 1'b1 == pulse_num_q) begin
                        state_d = WAIT_ACK;
                    end else if (!capture_en_i) begin
                        state_d = IDLE;
                    end else begin
                        hold_cnt_d = '0;
                        state_d    = HOLD;
                    end
                end else begin
                    sample_cnt_d = sample_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!capture_en_i) begin
                    state_d = IDLE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ARM;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            WAIT_ACK: begin
                if (frame_ack_i) begin
                    if (capture_en_i && cfg_ok) begin
                        sample_num_d = sample_num_i;
                        pulse_num_d  = pulse_num_i;
                        pulse_cnt_d  = '0;
                        state_d      = ARM;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state change.
    always_comb begin
        trigger_ready_d = (state_d == ARM);
        sample_valid_d  = (state_d == CAPTURE);
        first_pulse_d   = (state_d == CAPTURE) && (pulse_cnt_d == '0);
        frame_done_d    = (state_q == CAPTURE) && (state_d == WAIT_ACK);
        busy_d          = (state_d != IDLE);
    end

    assign trigger_ready_o = trigger_ready_q;
    assign sample_valid_o  = sample_valid_q;
    assign first_pulse_o   = first_pulse_q;
    assign frame_done_o    = frame_done_q;
    assign busy_o          = busy_q;
    assign pulse_cnt_o     = pulse_cnt_q;

endmodule
